// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave port between MASTERS requesters.
// An in-order ID FIFO remembers which master owns each outstanding response.
module obi_rr_arbiter #(
  parameter  int MASTERS     = 3,
  parameter  int OUTSTANDING = 2,
  localparam int IDX_W       = $clog2(MASTERS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [MASTERS-1:0] req_i,
  output logic [MASTERS-1:0] gnt_o,
  output logic [MASTERS-1:0] rvalid_o,
  output logic [IDX_W-1:0]   req_sel_o,
  output logic [IDX_W-1:0]   rsp_sel_o,
  output logic               slave_req_o,
  input  logic               slave_gnt_i,
  input  logic               slave_rvalid_i,
  output logic               busy_o,
  output logic               proto_err_o
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [IDX_W-1:0] LAST_M = IDX_W'(MASTERS - 1);
  localparam logic [PTR_W-1:0] LAST_P = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(OUTSTANDING);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] fifo_q [OUTSTANDING];
  logic [IDX_W-1:0] fifo_d [OUTSTANDING];

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] head;
  logic             found;
  logic             can_push;
  logic             hs;
  logic             pop;
  int               idx;

  // Scan from rr_ptr upward, wrapping, and take the first requester.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < MASTERS; i++) begin
      idx = (int'(rr_ptr_q) + i) % MASTERS;
      if (!found && req_i[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  // A full FIFO still accepts when a response frees a slot in the same cycle.
  assign can_push    = (count_q < FULL_C) | slave_rvalid_i;
  assign slave_req_o = (|req_i) & can_push;
  assign hs          = slave_req_o & slave_gnt_i;
  assign gnt_o       = hs ? (MASTERS'(1) << winner) : '0;
  assign req_sel_o   = winner;

  assign busy_o      = (count_q != '0);
  assign head        = fifo_q[rd_ptr_q];
  assign pop         = slave_rvalid_i & busy_o;
  assign rsp_sel_o   = busy_o ? head : '0;
  assign rvalid_o    = pop ? (MASTERS'(1) << head) : '0;
  assign proto_err_o = err_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fifo_d   = fifo_q;
    err_d    = err_q | (slave_rvalid_i & ~busy_o);

    if (hs) begin
      fifo_d[wr_ptr_q] = winner;
      wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PTR_W'(1);
      rr_ptr_d = (winner == LAST_M) ? '0 : winner + IDX_W'(1);
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({hs, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      fifo_q   <= '{default: '0};
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      fifo_q   <= fifo_d;
    end
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_obi_rr_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [2:0] req_i;
  logic [2:0] gnt_o;
  logic [2:0] rvalid_o;
  logic [1:0] req_sel_o;
  logic [1:0] rsp_sel_o;
  logic       slave_req_o;
  logic       slave_gnt_i;
  logic       slave_rvalid_i;
  logic       busy_o;
  logic       proto_err_o;

  obi_rr_arbiter #(.MASTERS(3), .OUTSTANDING(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .req_sel_o      (req_sel_o),
    .rsp_sel_o      (rsp_sel_o),
    .slave_req_o    (slave_req_o),
    .slave_gnt_i    (slave_gnt_i),
    .slave_rvalid_i (slave_rvalid_i),
    .busy_o         (busy_o),
    .proto_err_o    (proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0] v;
    logic [1:0] sel;
  } exp_t;

  exp_t gnt_q[$];
  exp_t rsp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic g, input logic v);
    @(posedge clk_i);
    #1;
    req_i          = r;
    slave_gnt_i    = g;
    slave_rvalid_i = v;
  endtask

  task automatic exp_gnt(input logic [2:0] v, input logic [1:0] sel);
    exp_t e;
    e.v = v;
    e.sel = sel;
    gnt_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [2:0] v, input logic [1:0] sel);
    exp_t e;
    e.v = v;
    e.sel = sel;
    rsp_q.push_back(e);
  endtask

  // Monitor: every presented grant/response must match the next queued expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i) begin
      if (gnt_o != 3'b000) begin
        if (gnt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_gnt actual=%b required=none", gnt_o);
        end else begin
          e = gnt_q.pop_front();
          chk("gnt_o", 32'(gnt_o), 32'(e.v));
          chk("req_sel_o", 32'(req_sel_o), 32'(e.sel));
        end
      end
      if (rvalid_o != 3'b000) begin
        if (rsp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rvalid actual=%b required=none", rvalid_o);
        end else begin
          e = rsp_q.pop_front();
          chk("rvalid_o", 32'(rvalid_o), 32'(e.v));
          chk("rsp_sel_o", 32'(rsp_sel_o), 32'(e.sel));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i          = 1'b1;
    req_i          = 3'b111;
    slave_gnt_i    = 1'b1;
    slave_rvalid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i       = 1'b0;
    req_i       = 3'b000;
    slave_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_rvalid", 32'(rvalid_o), 0);
    chk("rst_slave_req", 32'(slave_req_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_req_sel", 32'(req_sel_o), 0);
    chk("rst_rsp_sel", 32'(rsp_sel_o), 0);
    chk("rst_proto_err", 32'(proto_err_o), 0);

    // Round robin 0,1,2,0 with responses one cycle behind
    drive(3'b111, 1, 0); exp_gnt(3'b001, 0);
    drive(3'b111, 1, 1); exp_gnt(3'b010, 1); exp_rsp(3'b001, 0);
    drive(3'b111, 1, 1); exp_gnt(3'b100, 2); exp_rsp(3'b010, 1);
    drive(3'b111, 1, 1); exp_gnt(3'b001, 0); exp_rsp(3'b100, 2);
    drive(3'b000, 0, 1); exp_rsp(3'b001, 0);
    drive(3'b000, 0, 0);
    @(negedge clk_i);
    chk("rr_drained_busy", 32'(busy_o), 0);

    // Fill to OUTSTANDING, then bypass full with a same-cycle response (rr_ptr=1)
    drive(3'b111, 1, 0); exp_gnt(3'b010, 1);
    drive(3'b111, 1, 0); exp_gnt(3'b100, 2);
    drive(3'b111, 1, 0);
    @(negedge clk_i);
    chk("full_slave_req", 32'(slave_req_o), 0);
    chk("full_gnt", 32'(gnt_o), 0);
    chk("full_busy", 32'(busy_o), 1);
    drive(3'b111, 1, 1); exp_gnt(3'b001, 0); exp_rsp(3'b010, 1);
    @(negedge clk_i);
    chk("bypass_slave_req", 32'(slave_req_o), 1);
    drive(3'b111, 1, 0);
    @(negedge clk_i);
    chk("still_full_slave_req", 32'(slave_req_o), 0);
    drive(3'b000, 0, 1); exp_rsp(3'b100, 2);
    drive(3'b000, 0, 1); exp_rsp(3'b001, 0);
    drive(3'b000, 0, 0);
    @(negedge clk_i);
    chk("full_drained_busy", 32'(busy_o), 0);

    // Routing: m2 then m0, responses return in order (rr_ptr=1)
    drive(3'b100, 1, 0); exp_gnt(3'b100, 2);
    drive(3'b001, 1, 0); exp_gnt(3'b001, 0);
    drive(3'b000, 0, 1); exp_rsp(3'b100, 2);
    drive(3'b000, 0, 1); exp_rsp(3'b001, 0);
    drive(3'b000, 0, 0);

    // Stray response with empty FIFO
    drive(3'b000, 0, 1);
    @(negedge clk_i);
    chk("stray_rvalid", 32'(rvalid_o), 0);
    chk("stray_rsp_sel", 32'(rsp_sel_o), 0);
    drive(3'b000, 0, 0);
    @(negedge clk_i);
    chk("proto_err_set", 32'(proto_err_o), 1);
    chk("stray_busy", 32'(busy_o), 0);
    repeat (3) drive(3'b000, 0, 0);
    @(negedge clk_i);
    chk("proto_err_sticky", 32'(proto_err_o), 1);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("proto_err_cleared", 32'(proto_err_o), 0);

    // Stall: m1 requests, slave withholds grant; rr_ptr must stay 0
    for (int i = 0; i < 5; i++) begin
      drive(3'b010, 0, 0);
      @(negedge clk_i);
      chk("stall_gnt", 32'(gnt_o), 0);
      chk("stall_slave_req", 32'(slave_req_o), 1);
    end
    drive(3'b010, 1, 0); exp_gnt(3'b010, 1);
    drive(3'b111, 1, 0); exp_gnt(3'b100, 2);
    drive(3'b000, 0, 1); exp_rsp(3'b010, 1);
    drive(3'b000, 0, 1); exp_rsp(3'b100, 2);
    drive(3'b000, 0, 0);
    @(negedge clk_i);
    chk("end_busy", 32'(busy_o), 0);

    @(posedge clk_i);
    chk("gnt_queue_empty", 32'(gnt_q.size()), 0);
    chk("rsp_queue_empty", 32'(rsp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
